// File: rtl/dbg_pkg.sv
// ---------------------------------------------------------------------------
// dbg_pkg
//   Shared definitions for the UART debug read path.
//   - SRC_*          : 3-bit source codes carried in address byte bits [7:5]
//   - state_e        : 3-bit state encoding used by the sequencer and the
//                      byte serializer
//   - RD_WAIT_DEFAULT: default memory read latency in cycles
//   - src_is_mem()   : true for sources that need the RF/DM read latency
// ---------------------------------------------------------------------------
package dbg_pkg;

   localparam logic [2:0] SRC_RF   = 3'b000;
   localparam logic [2:0] SRC_PC   = 3'b001;
   localparam logic [2:0] SRC_INST = 3'b010;
   localparam logic [2:0] SRC_CNTL = 3'b011;
   localparam logic [2:0] SRC_A    = 3'b100;
   localparam logic [2:0] SRC_B    = 3'b101;
   localparam logic [2:0] SRC_ALU  = 3'b110;
   localparam logic [2:0] SRC_DM   = 3'b111;

   localparam int RD_WAIT_DEFAULT = 8;
   localparam int DATA_W_DEFAULT  = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_SEND  = 3'd2,
      ST_START = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   // Register file and data memory are synchronous RAMs; everything else is
   // a plain register that is valid as soon as src_sel is.
   function automatic logic src_is_mem(input logic [2:0] code);
      return (code == SRC_RF) || (code == SRC_DM);
   endfunction

endpackage

// File: rtl/tx_byte_serializer.sv
// ---------------------------------------------------------------------------
// tx_byte_serializer
//   Holds the captured word and hands it to the UART TX core one byte at a
//   time, most significant byte first.
//   Ports:
//     clk_i       in   system clock
//     rst_ni      in   synchronous active-low reset
//     load_i      in   1-cycle: capture word_i and start sending
//     word_i      in   word to send
//     tx_busy_i   in   TX core busy
//     done_o      out  1-cycle (combinational): last byte's guard cycle
//     tx_start_o  out  registered 1-cycle start pulse
//     tx_data_o   out  registered byte to transmit
// ---------------------------------------------------------------------------
module tx_byte_serializer
   import dbg_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [DATA_W-1:0] word_i,
   input  logic              tx_busy_i,
   output logic              done_o,
   output logic              tx_start_o,
   output logic [7:0]        tx_data_o
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [1:0]        idx_q, idx_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_start_q, tx_start_d;

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      idx_d      = idx_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_i) begin
               word_d  = word_i;
               idx_d   = 2'd3;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!tx_busy_i) begin
               tx_data_d  = word_q[{idx_q, 3'b000} +: 8];
               // Registered pulse: high during the START cycle only.
               tx_start_d = 1'b1;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            state_d = ST_GAP;
         end
         ST_GAP: begin
            // tx_busy rises one cycle after tx_start; this guard cycle keeps
            // SEND from seeing a stale idle TX core.
            if (idx_q == 2'd0) begin
               state_d = ST_IDLE;
            end else begin
               idx_d   = idx_q - 2'd1;
               state_d = ST_SEND;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         word_q     <= '0;
         idx_q      <= 2'd0;
         tx_data_q  <= 8'd0;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
      end
   end

   assign done_o     = (state_q == ST_GAP) && (idx_q == 2'd0);
   assign tx_start_o = tx_start_q;
   assign tx_data_o  = tx_data_q;

endmodule

// File: rtl/debug_read_sequencer.sv
// ---------------------------------------------------------------------------
// debug_read_sequencer
//   Sequences one UART debug read: decodes the received address byte, drives
//   the debug mux select and RF/DM read indices, waits out the read latency,
//   captures the selected word and sends it as 4 bytes, MSB first.
//   Ports:
//     clk_i          in   system clock
//     rst_ni         in   synchronous active-low reset
//     rx_valid_i     in   1-cycle: rx_data_i holds a received byte
//     rx_data_i      in   [7:5] source code, [4:0] RF/DM index
//     data_sel_32_i  in   mux output for the current src_sel_o
//     src_sel_o      out  source code to the mux
//     addr_rf_5_o    out  register-file read index
//     addr_dm_5_o    out  data-memory read index
//     tx_busy_i      in   TX core busy
//     tx_start_o     out  1-cycle byte start pulse
//     tx_data_o      out  byte to transmit
//     busy_o         out  sequencer not idle
//     rx_drop_o      out  1-cycle: a byte arrived while busy and was dropped
//     rd_done_o      out  1-cycle: last byte handed to TX
// ---------------------------------------------------------------------------
module debug_read_sequencer
   import dbg_pkg::*;
#(
   parameter int RD_WAIT = RD_WAIT_DEFAULT,
   parameter int DATA_W  = DATA_W_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   input  logic [DATA_W-1:0] data_sel_32_i,
   output logic [2:0]        src_sel_o,
   output logic [4:0]        addr_rf_5_o,
   output logic [4:0]        addr_dm_5_o,
   input  logic              tx_busy_i,
   output logic              tx_start_o,
   output logic [7:0]        tx_data_o,
   output logic              busy_o,
   output logic              rx_drop_o,
   output logic              rd_done_o
);

   // RD_WAIT == 1 would give a zero-width counter; keep at least one bit.
   localparam int              CNT_W    = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_WAIT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       src_sel_q, src_sel_d;
   logic [4:0]       addr_rf_q, addr_rf_d;
   logic [4:0]       addr_dm_q, addr_dm_d;
   logic             busy_q, busy_d;
   logic             rx_drop_q, rx_drop_d;
   logic             rd_done_q, rd_done_d;

   logic             ser_load;
   logic             ser_done;
   logic [2:0]       rx_code;

   assign rx_code = rx_data_i[7:5];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      src_sel_d = src_sel_q;
      addr_rf_d = addr_rf_q;
      addr_dm_d = addr_dm_q;
      rx_drop_d = 1'b0;
      rd_done_d = 1'b0;
      ser_load  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_valid_i) begin
               src_sel_d = rx_code;
               if (rx_code == SRC_RF) begin
                  addr_rf_d = rx_data_i[4:0];
               end
               if (rx_code == SRC_DM) begin
                  addr_dm_d = rx_data_i[4:0];
               end
               cnt_d   = src_is_mem(rx_code) ? CNT_LOAD : '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               ser_load = 1'b1;
               state_d  = ST_SEND;
            end
         end
         ST_SEND: begin
            // The serializer walks SEND/START/GAP for all four bytes; this
            // FSM just waits for its final guard cycle.
            if (ser_done) begin
               rd_done_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (rx_valid_i && (state_q != ST_IDLE)) begin
         rx_drop_d = 1'b1;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         src_sel_q <= 3'd0;
         addr_rf_q <= 5'd0;
         addr_dm_q <= 5'd0;
         busy_q    <= 1'b0;
         rx_drop_q <= 1'b0;
         rd_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         src_sel_q <= src_sel_d;
         addr_rf_q <= addr_rf_d;
         addr_dm_q <= addr_dm_d;
         busy_q    <= busy_d;
         rx_drop_q <= rx_drop_d;
         rd_done_q <= rd_done_d;
      end
   end

   tx_byte_serializer #(
      .DATA_W (DATA_W)
   ) u_ser (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (ser_load),
      .word_i     (data_sel_32_i),
      .tx_busy_i  (tx_busy_i),
      .done_o     (ser_done),
      .tx_start_o (tx_start_o),
      .tx_data_o  (tx_data_o)
   );

   assign src_sel_o   = src_sel_q;
   assign addr_rf_5_o = addr_rf_q;
   assign addr_dm_5_o = addr_dm_q;
   assign busy_o      = busy_q;
   assign rx_drop_o   = rx_drop_q;
   assign rd_done_o   = rd_done_q;

endmodule

// File: tb/tb_debug_read_sequencer.sv
// ---------------------------------------------------------------------------
// tb_debug_read_sequencer
//   Directed bench for debug_read_sequencer (RD_WAIT = 8). Inputs change 1
//   time unit after the rising edge; tx_start/rd_done are logged on the
//   falling edge together with the cycle number.
// ---------------------------------------------------------------------------
module tb_debug_read_sequencer;

   logic        clk;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic [31:0] data_sel;
   logic        tx_busy;
   logic [2:0]  src_sel;
   logic [4:0]  addr_rf;
   logic [4:0]  addr_dm;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        busy;
   logic        rx_drop;
   logic        rd_done;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int t0      = 0;

   int          ev_cyc[$];
   logic [7:0]  ev_data[$];
   logic        done_seen;
   int          done_cyc;

   debug_read_sequencer #(
      .RD_WAIT (8),
      .DATA_W  (32)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .rx_valid_i    (rx_valid),
      .rx_data_i     (rx_data),
      .data_sel_32_i (data_sel),
      .src_sel_o     (src_sel),
      .addr_rf_5_o   (addr_rf),
      .addr_dm_5_o   (addr_dm),
      .tx_busy_i     (tx_busy),
      .tx_start_o    (tx_start),
      .tx_data_o     (tx_data),
      .busy_o        (busy),
      .rx_drop_o     (rx_drop),
      .rd_done_o     (rd_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         ev_cyc.push_back(cyc);
         ev_data.push_back(tx_data);
      end
      if (rd_done === 1'b1 && !done_seen) begin
         done_seen = 1'b1;
         done_cyc  = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ev();
      ev_cyc.delete();
      ev_data.delete();
      done_seen = 1'b0;
      done_cyc  = -1;
   endtask

   // Drive one rx byte during cycle T (recorded in t0); returns at T+1.
   task automatic send_rx(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      t0       = cyc;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cycles);
      int n;
      n = 0;
      while (!done_seen && n < max_cycles) begin
         step();
         n++;
      end
      chk({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
      step();
   endtask

   task automatic check_txn(input string tag, input logic [31:0] word,
                            input int c0, input int c1, input int c2, input int c3);
      int exp_c[4];
      logic [7:0] exp_b;
      exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2; exp_c[3] = c3;
      chk({tag, "_n_starts"}, ev_data.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         exp_b = word[8*(3-i) +: 8];
         chk($sformatf("%s_byte%0d", tag, i), {24'd0, ev_data[i]}, {24'd0, exp_b});
         chk($sformatf("%s_cyc%0d", tag, i), ev_cyc[i] - t0, exp_c[i] - t0);
      end
      chk({tag, "_rd_done_cyc"}, done_cyc - t0, c3 + 2 - t0);
      $display("[TB] txn %s: word %08h, %0d starts, first at T+%0d, rd_done at T+%0d",
               tag, word, ev_data.size(), (ev_cyc.size() > 0) ? ev_cyc[0] - t0 : -1,
               done_cyc - t0);
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      data_sel = 32'h0;
      tx_busy  = 1'b0;
      done_seen = 1'b0;
      done_cyc  = -1;

      // ---------------- reset state ----------------
      repeat (3) step();
      chk("rst_src_sel",  {29'd0, src_sel}, 32'd0);
      chk("rst_addr_rf",  {27'd0, addr_rf}, 32'd0);
      chk("rst_addr_dm",  {27'd0, addr_dm}, 32'd0);
      chk("rst_tx_data",  {24'd0, tx_data}, 32'd0);
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_busy",     {31'd0, busy}, 32'd0);
      chk("rst_rx_drop",  {31'd0, rx_drop}, 32'd0);
      chk("rst_rd_done",  {31'd0, rd_done}, 32'd0);
      rst_n = 1'b1;
      step();
      $display("[TB] txn reset: outputs checked");

      // ---------------- PC read, register source ----------------
      clear_ev();
      data_sel = 32'hDEADBEEF;
      send_rx(8'h20);
      chk("pc_src_sel", {29'd0, src_sel}, 32'd1);
      chk("pc_busy",    {31'd0, busy}, 32'd1);
      wait_done("pc", 60);
      check_txn("pc", 32'hDEADBEEF, t0 + 3, t0 + 6, t0 + 9, t0 + 12);
      chk("pc_idle_busy", {31'd0, busy}, 32'd0);

      // ---------------- RF read, idx 5, capture at T+8 ----------------
      clear_ev();
      data_sel = 32'h11111111;
      send_rx(8'h05);
      chk("rf_addr_rf", {27'd0, addr_rf}, 32'd5);
      chk("rf_src_sel", {29'd0, src_sel}, 32'd0);
      chk("rf_addr_dm", {27'd0, addr_dm}, 32'd0);
      repeat (3) step();              // cycle T+4
      data_sel = 32'hAAAA5555;
      repeat (4) step();              // cycle T+8
      data_sel = 32'h12345678;
      step();                         // cycle T+9, after capture
      data_sel = 32'h99999999;
      wait_done("rf", 60);
      check_txn("rf", 32'h12345678, t0 + 10, t0 + 13, t0 + 16, t0 + 19);

      // ---------------- DM read idx 3 with a 20-cycle TX stall ----------------
      clear_ev();
      data_sel = 32'hA1B2C3D4;
      send_rx(8'hE3);
      chk("dm_addr_dm", {27'd0, addr_dm}, 32'd3);
      chk("dm_addr_rf", {27'd0, addr_rf}, 32'd5);
      chk("dm_src_sel", {29'd0, src_sel}, 32'd7);
      for (int n = 0; n < 40 && ev_data.size() < 1; n++) step();
      chk("dm_first_start_seen", ev_data.size(), 32'd1);
      tx_busy = 1'b1;                 // cycle T+11
      repeat (20) step();
      chk("dm_no_start_in_stall", ev_data.size(), 32'd1);
      tx_busy = 1'b0;                 // cycle T+31
      wait_done("dm", 60);
      check_txn("dm", 32'hA1B2C3D4, t0 + 10, t0 + 32, t0 + 35, t0 + 38);

      // ---------------- rx during WAIT and SEND is dropped ----------------
      clear_ev();
      data_sel = 32'h0BADF00D;
      send_rx(8'h0A);
      repeat (2) step();              // cycle T+3, WAIT
      rx_valid = 1'b1;
      rx_data  = 8'hFF;
      step();
      rx_valid = 1'b0;
      chk("drop_wait_pulse",  {31'd0, rx_drop}, 32'd1);
      chk("drop_wait_src",    {29'd0, src_sel}, 32'd0);
      chk("drop_wait_rf",     {27'd0, addr_rf}, 32'd10);
      chk("drop_wait_dm",     {27'd0, addr_dm}, 32'd3);
      step();
      chk("drop_wait_clear",  {31'd0, rx_drop}, 32'd0);
      repeat (4) step();              // cycle T+9, SEND
      rx_valid = 1'b1;
      rx_data  = 8'h20;
      step();                         // cycle T+10
      rx_valid = 1'b0;
      chk("drop_send_pulse",  {31'd0, rx_drop}, 32'd1);
      chk("drop_send_src",    {29'd0, src_sel}, 32'd0);
      chk("drop_send_start",  {31'd0, tx_start}, 32'd1);
      wait_done("drop", 60);
      check_txn("drop", 32'h0BADF00D, t0 + 10, t0 + 13, t0 + 16, t0 + 19);

      // ---------------- reset in GAP of byte 2 ----------------
      clear_ev();
      data_sel = 32'h55667788;
      send_rx(8'h20);
      repeat (6) step();              // cycle T+7, GAP after 2nd start
      chk("abort_two_starts", ev_data.size(), 32'd2);
      rst_n = 1'b0;
      step();                         // cycle T+8
      rst_n = 1'b1;
      chk("abort_src_sel",  {29'd0, src_sel}, 32'd0);
      chk("abort_addr_rf",  {27'd0, addr_rf}, 32'd0);
      chk("abort_addr_dm",  {27'd0, addr_dm}, 32'd0);
      chk("abort_tx_data",  {24'd0, tx_data}, 32'd0);
      chk("abort_tx_start", {31'd0, tx_start}, 32'd0);
      chk("abort_busy",     {31'd0, busy}, 32'd0);
      chk("abort_rd_done",  {31'd0, rd_done}, 32'd0);
      repeat (12) step();
      chk("abort_no_more_starts", ev_data.size(), 32'd2);
      chk("abort_no_done", {31'd0, done_seen}, 32'd0);
      $display("[TB] txn abort: reset in GAP, %0d starts before reset", ev_data.size());

      clear_ev();
      data_sel = 32'hC0FFEE11;
      send_rx(8'hC0);
      chk("alu_src_sel", {29'd0, src_sel}, 32'd6);
      chk("alu_addr_rf", {27'd0, addr_rf}, 32'd0);
      wait_done("alu", 60);
      check_txn("alu", 32'hC0FFEE11, t0 + 3, t0 + 6, t0 + 9, t0 + 12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
